// File: rtl/radiant_scaler_pkg.sv
// Shared constants for the scaler bank: register word addresses, CTRL bit positions, count width.
// Optional prescaler controlled by RADIANT_SCALER_PRESCALE_EN.
package radiant_scaler_pkg;

  localparam int COUNT_WIDTH     = 16;
  localparam int PRESCALE_WIDTH  = 3;
  localparam int PRESC_CNT_WIDTH = 8;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_PERIOD    = 6'h01;
  localparam logic [5:0] ADDR_UPDCNT    = 6'h02;
  localparam logic [5:0] ADDR_SCAL_BASE = 6'h10;

  localparam int CTRL_GATE_SEL     = 0;
  localparam int CTRL_FREEZE       = 1;
  localparam int CTRL_CLEAR        = 2;
  localparam int CTRL_PRESCALE_LSB = 4;

  // Low p bits of the prescaler that must roll over before the counter advances.
  function automatic logic [PRESC_CNT_WIDTH-1:0] prescale_mask(input logic [PRESCALE_WIDTH-1:0] p);
    return PRESC_CNT_WIDTH'((32'd1 << p) - 32'd1);
  endfunction

endpackage

// File: rtl/radiant_scaler_counter.sv
// One scaler channel: saturating flag counter latched into a holding register on gate end.
// Optional per-channel prescaler when RADIANT_SCALER_PRESCALE_EN is defined.
module radiant_scaler_counter
  import radiant_scaler_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flag_i,
  input  logic                      latch_i,
  input  logic                      clear_i,
  input  logic                      freeze_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [COUNT_WIDTH-1:0]    hold_o
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] hold_q, hold_d;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   inc;

`ifdef RADIANT_SCALER_PRESCALE_EN
  logic [PRESC_CNT_WIDTH-1:0] presc_q, presc_d, presc_next;

  assign presc_next = presc_q + PRESC_CNT_WIDTH'(1);
  assign inc        = flag_i && ((presc_next & prescale_mask(prescale_i)) == '0);

  always_comb begin
    presc_d = presc_q;
    if (clear_i || latch_i)
      presc_d = '0;
    else if (!freeze_i && flag_i)
      presc_d = presc_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) presc_q <= '0;
    else       presc_q <= presc_d;
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_i;
  assign inc             = flag_i;
`endif

  // Sticks at all-ones; a same-cycle flag is folded into the latched value.
  assign count_inc = (&count_q) ? count_q : count_q + COUNT_WIDTH'(inc);

  always_comb begin
    count_d = count_q;
    hold_d  = hold_q;
    if (clear_i) begin
      count_d = '0;
    end else if (!freeze_i) begin
      if (latch_i) begin
        hold_d  = count_inc;
        count_d = '0;
      end else begin
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  assign hold_o = hold_q;

endmodule

// File: rtl/radiant_scaler_bank.sv
// Scaler bank top: gate timer, CTRL/PERIOD/UPDCNT registers, Wishbone slave, NUM_CH counters.
// CTRL[6:4] prescale field exists only when RADIANT_SCALER_PRESCALE_EN is defined.
module radiant_scaler_bank
  import radiant_scaler_pkg::*;
#(
  parameter int          NUM_CH         = 24,
  parameter logic [31:0] PERIOD_DEFAULT = 32'd50000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [5:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  input  logic              pps_i,
  input  logic [NUM_CH-1:0] scal_i,
  output logic              update_o
);

  logic                      ack_q, update_q, gate_sel_q, freeze_q;
  logic [31:0]               dat_q, period_q, timer_q, timer_d, updcnt_q;
  logic [31:0]               period_eff, rd_data;
  logic                      bus_req, wr_en, ctrl_wr, period_wr, clear, gate_end, latch;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [COUNT_WIDTH-1:0]    hold [NUM_CH];
  logic                      unused_sel;

  assign unused_sel = ^wb_sel_i;

  assign bus_req   = wb_cyc_i && wb_stb_i && !ack_q;
  assign wr_en     = ack_q && wb_cyc_i && wb_stb_i && wb_we_i;
  assign ctrl_wr   = wr_en && (wb_adr_i == ADDR_CTRL);
  assign period_wr = wr_en && (wb_adr_i == ADDR_PERIOD);
  assign clear     = ctrl_wr && wb_dat_i[CTRL_CLEAR];

  // >= rather than == so a PERIOD shrunk below the running timer still closes the gate.
  assign period_eff = (period_q == '0) ? 32'd1 : period_q;
  assign gate_end   = gate_sel_q ? pps_i : (timer_q >= period_eff - 32'd1);
  assign latch      = gate_end && !freeze_q && !clear;

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (clear || (ctrl_wr && (wb_dat_i[CTRL_GATE_SEL] != gate_sel_q)))
      timer_d = '0;
    else if (freeze_q)
      timer_d = timer_q;
    else if (gate_sel_q || gate_end)
      timer_d = '0;
  end

`ifdef RADIANT_SCALER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        prescale_q <= '0;
    else if (ctrl_wr) prescale_q <= wb_dat_i[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
  end
  assign prescale = prescale_q;
`else
  assign prescale = '0;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    radiant_scaler_counter u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flag_i     (scal_i[gi]),
      .latch_i    (latch),
      .clear_i    (clear),
      .freeze_i   (freeze_q),
      .prescale_i (prescale),
      .hold_o     (hold[gi])
    );
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADDR_CTRL: begin
        rd_data[CTRL_GATE_SEL]                             = gate_sel_q;
        rd_data[CTRL_FREEZE]                               = freeze_q;
        rd_data[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH]       = prescale;
      end
      ADDR_PERIOD: rd_data = period_q;
      ADDR_UPDCNT: rd_data = updcnt_q;
      default: begin
        for (int k = 0; k < NUM_CH / 2; k++)
          if (wb_adr_i == ADDR_SCAL_BASE + 6'(k))
            rd_data = {hold[2*k+1], hold[2*k]};
      end
    endcase
  end

  // Read data is captured on the strobe cycle, so a latch on the ack cycle is not visible yet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      gate_sel_q <= 1'b0;
      freeze_q   <= 1'b0;
      period_q   <= PERIOD_DEFAULT;
      timer_q    <= '0;
      updcnt_q   <= '0;
      update_q   <= 1'b0;
    end else begin
      ack_q    <= bus_req;
      timer_q  <= timer_d;
      update_q <= latch;
      if (bus_req)   dat_q    <= rd_data;
      if (latch)     updcnt_q <= updcnt_q + 32'd1;
      if (period_wr) period_q <= wb_dat_i;
      if (ctrl_wr) begin
        gate_sel_q <= wb_dat_i[CTRL_GATE_SEL];
        freeze_q   <= wb_dat_i[CTRL_FREEZE];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign update_o = update_q;

endmodule

// File: tb/tb_radiant_scaler_bank.sv
// Randomised bench for radiant_scaler_bank against a flag-counting reference model.
// Build with RADIANT_SCALER_PRESCALE_EN defined to exercise the prescale field.
module tb_radiant_scaler_bank;

  localparam int NCH = 24;
`ifdef RADIANT_SCALER_PRESCALE_EN
  localparam bit PRESC_EN = 1'b1;
`else
  localparam bit PRESC_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, pps = 1'b0;
  logic [5:0]  adr = '0;
  logic [31:0] dat_i = '0, dat_o;
  logic [3:0]  sel = 4'hF;
  logic        ack, err, rty, update;
  logic [NCH-1:0] scal = '0;

  radiant_scaler_bank #(.NUM_CH(NCH)) dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .pps_i(pps),
    .scal_i(scal), .update_o(update)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Reference model: raw flag totals per gate period, reduced to a hold value only at latch time.
  int unsigned raw_m [NCH];
  logic [15:0] hold_m [NCH];
  logic [31:0] period_m, updcnt_m, elapsed_m;
  logic        gsel_m, frz_m, ack_m, latched_m;
  logic [2:0]  p_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin raw_m[ch] = 0; hold_m[ch] = '0; end
    period_m = 32'd50000000; updcnt_m = '0; elapsed_m = '0;
    gsel_m = 1'b0; frz_m = 1'b0; ack_m = 1'b0; p_m = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [5:0] a);
    if (a == 6'h00) return {25'd0, p_m, 2'b00, frz_m, gsel_m};
    if (a == 6'h01) return period_m;
    if (a == 6'h02) return updcnt_m;
    if (a >= 6'h10 && a < 6'h10 + 6'(NCH / 2))
      return {hold_m[2*(a-6'h10)+1], hold_m[2*(a-6'h10)]};
    return '0;
  endfunction

  // Advance one clock and apply the gate/count/bus rules to the model for that edge.
  task automatic tick();
    logic wr, clr, gchg, gate;
    logic [31:0] peff;
    int unsigned v;
    @(posedge clk);
    #1;
    latched_m = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      wr   = ack_m && cyc && stb && we;
      clr  = wr && adr == 6'h00 && dat_i[2];
      gchg = wr && adr == 6'h00 && (dat_i[0] != gsel_m);
      peff = (period_m == 0) ? 32'd1 : period_m;
      gate = gsel_m ? pps : (elapsed_m == peff - 32'd1);
      if (!frz_m)
        for (int ch = 0; ch < NCH; ch++) if (scal[ch]) raw_m[ch]++;
      latched_m = gate && !frz_m && !clr;
      if (clr) begin
        for (int ch = 0; ch < NCH; ch++) raw_m[ch] = 0;
      end else if (latched_m) begin
        for (int ch = 0; ch < NCH; ch++) begin
          v = raw_m[ch] >> p_m;
          hold_m[ch] = (v > 65535) ? 16'hFFFF : v[15:0];
          raw_m[ch] = 0;
        end
        updcnt_m++;
      end
      if (clr || gchg || (!frz_m && (gsel_m || gate))) elapsed_m = '0;
      else if (!frz_m) elapsed_m++;
      ack_m = cyc && stb && !ack_m;
      if (wr && adr == 6'h00) begin
        gsel_m = dat_i[0]; frz_m = dat_i[1];
        if (PRESC_EN) p_m = dat_i[6:4];
      end
      if (wr && adr == 6'h01) period_m = dat_i;
    end
    check("update_o", 32'(update), 32'(latched_m));
    check("wb_ack_o", 32'(ack), 32'(ack_m));
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
    scal = '0; pps = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
    tick();
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("wr  adr=%02h dat=%08h", a, d);
  endtask

  task automatic wb_read(input string tag, input logic [5:0] a, output logic [31:0] d);
    logic [31:0] e;
    scal = '0; pps = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    e = exp_rd(a);
    tick();
    d = dat_o;
    check(tag, d, e);
    cyc = 1'b0; stb = 1'b0;
    tick();
    $display("rd  adr=%02h dat=%08h", a, d);
  endtask

  task automatic read_all(input string tag);
    logic [31:0] d;
    for (int k = 0; k < NCH / 2; k++)
      wb_read($sformatf("%s_word%0d", tag, k), 6'h10 + 6'(k), d);
    wb_read({tag, "_updcnt"}, 6'h02, d);
    wb_read({tag, "_unmapped"}, 6'h1C, d);
  endtask

  task automatic wait_gate(input string tag, input int bound);
    scal = '0; pps = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (latched_m) return;
    end
    timeout(tag);
  endtask

  task automatic wait_elapsed(input string tag, input logic [31:0] target, input int bound);
    scal = '0; pps = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (elapsed_m == target) return;
      tick();
    end
    timeout(tag);
  endtask

  logic [31:0] d, u0;

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("err_rst", 32'(err), 32'd0);
    check("rty_rst", 32'(rty), 32'd0);
    wb_read("ctrl_rst", 6'h00, d);   check("ctrl_rst_val", d, 32'd0);
    wb_read("period_rst", 6'h01, d); check("period_rst_val", d, 32'd50000000);
    wb_read("updcnt_rst", 6'h02, d); check("updcnt_rst_val", d, 32'd0);
    wb_read("word0_rst", 6'h10, d);  check("word0_rst_val", d, 32'd0);
    wb_read("unmapped_rst", 6'h3F, d);

    // Internal gate, PERIOD = 100
    wb_write(6'h01, 32'd100);
    wb_write(6'h00, 32'h4);
    wait_gate("int_align", 300);
    for (int i = 0; i < 100; i++) begin
      scal = (NCH'($urandom) & 24'hFFFFF0) | 24'h1 | ((i < 37) ? 24'h8 : 24'h0);
      tick();
    end
    wb_read("int_w10", 6'h10, d); check("int_w10_val", d, {16'd0, 16'd100});
    wb_read("int_w11", 6'h11, d); check("int_ch3", {16'd0, d[31:16]}, 32'd37);
    wb_read("int_updcnt", 6'h02, d);
    read_all("int");

    // Flag on channel 2 coincident with gate end
    wait_gate("coin_align", 300);
    for (int i = 0; i < 100; i++) begin
      scal = (NCH'($urandom) & 24'hFFFFF0) | ((i == 99) ? 24'h4 : 24'h0);
      tick();
    end
    wb_read("coin_w11", 6'h11, d); check("coin_ch2", {16'd0, d[15:0]}, 32'd1);
    wait_gate("coin_next", 300);
    wb_read("coin_w11b", 6'h11, d); check("coin_ch2_next", {16'd0, d[15:0]}, 32'd0);

    // CLEAR landing on the gate-end edge
    wait_elapsed("clr_align", 32'd98, 300);
    u0 = updcnt_m;
    wb_write(6'h00, 32'h4);
    wb_read("clr_updcnt", 6'h02, d); check("clr_updcnt_val", d, u0);

    // Prescale p = 3, 80 flags on channel 7
    wb_write(6'h00, 32'h34);
    wait_gate("psc_align", 300);
    for (int i = 0; i < 100; i++) begin
      scal = (NCH'($urandom) & 24'hFFFF7F) | ((i < 80) ? 24'h80 : 24'h0);
      tick();
    end
    wb_read("psc_w13", 6'h13, d);
    check("psc_ch7", {16'd0, d[31:16]}, PRESC_EN ? 32'd10 : 32'd80);
    wb_read("psc_ctrl", 6'h00, d);
    check("psc_ctrl_p", {29'd0, d[6:4]}, PRESC_EN ? 32'd3 : 32'd0);
    read_all("psc");
    wb_write(6'h00, 32'h4);

    // Saturation: PERIOD = 70000, channel 1 every cycle
    wb_write(6'h01, 32'd70000);
    wb_write(6'h00, 32'h4);
    begin : sat_loop
      for (int i = 0; i < 80000; i++) begin
        scal = NCH'($urandom) | 24'h2;
        tick();
        if (latched_m) disable sat_loop;
      end
      timeout("sat_gate");
    end
    wb_read("sat_w10", 6'h10, d); check("sat_ch1", {16'd0, d[31:16]}, 32'h0000FFFF);
    read_all("sat");

    // PPS gate: two pulses 500 cycles apart, channel 5 every 10 cycles
    wb_write(6'h00, 32'h5);
    for (int i = 0; i <= 500; i++) begin
      pps  = (i == 0 || i == 500);
      scal = (NCH'($urandom) & 24'hFFFFDF) | ((i > 0 && i % 10 == 0) ? 24'h20 : 24'h0);
      tick();
    end
    pps = 1'b0;
    wb_read("pps_w12", 6'h12, d); check("pps_ch5", {16'd0, d[31:16]}, 32'd50);
    read_all("pps");

    // FREEZE across two PPS pulses
    u0 = updcnt_m;
    wb_write(6'h00, 32'h3);
    for (int i = 0; i < 300; i++) begin
      pps  = (i == 50 || i == 250);
      scal = NCH'($urandom);
      tick();
    end
    pps = 1'b0;
    wb_read("frz_updcnt", 6'h02, d); check("frz_updcnt_val", d, u0);
    read_all("frz");

    // Random internal periods
    wb_write(6'h00, 32'h4);
    wb_write(6'h01, 32'($urandom_range(60, 20)));
    for (int i = 0; i < 400; i++) begin
      scal = NCH'($urandom) & NCH'($urandom);
      tick();
    end
    read_all("rnd");

    // Reset during an active read
    scal = '0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h02;
    #2 rst = 1'b1;
    #1 check("ack_in_rst", 32'(ack), 32'd0);
    tick();
    tick();
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    tick();
    wb_read("ctrl_post", 6'h00, d);   check("ctrl_post_val", d, 32'd0);
    wb_read("period_post", 6'h01, d); check("period_post_val", d, 32'd50000000);
    wb_read("updcnt_post", 6'h02, d); check("updcnt_post_val", d, 32'd0);
    wb_read("word5_post", 6'h15, d);  check("word5_post_val", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
